// File: rtl/logic_lab_unit.sv
// Switch-to-LED logic lab: eight selectable bitwise ops on synchronised switches,
// with debounced mode/load buttons and an accumulator fed back as a third operand.

module logic_lab_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign pulse = level & ~level_q;
endmodule

module logic_lab_unit #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_a,
  input  logic [WIDTH-1:0] sw_b,
  input  logic             btn_mode,
  input  logic             btn_load,
  output logic [WIDTH-1:0] led_result,
  output logic [2:0]       led_mode,
  output logic [WIDTH-1:0] led_acc,
  output logic             led_any
);
  logic [WIDTH-1:0] a_s1;
  logic [WIDTH-1:0] a_s2;
  logic [WIDTH-1:0] b_s1;
  logic [WIDTH-1:0] b_s2;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] acc_q;
  logic [2:0]       mode_q;
  logic             any_q;
  logic             mode_p;
  logic             load_p;

  logic_lab_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_mode),
    .pulse (mode_p)
  );

  logic_lab_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_load),
    .pulse (load_p)
  );

  always_comb begin
    result_c = '0;
    case (mode_q)
      3'd0:    result_c = ~a_s2;
      3'd1:    result_c = a_s2 | b_s2;
      3'd2:    result_c = a_s2 ^ b_s2;
      3'd3:    result_c = a_s2 & b_s2;
      3'd4:    result_c = ~(a_s2 & b_s2);
      3'd5:    result_c = ~(a_s2 | b_s2);
      3'd6:    result_c = ~(a_s2 ^ b_s2);
      default: result_c = a_s2 | b_s2 | acc_q;
    endcase
  end

  // The accumulator samples the registered result, so a simultaneous mode
  // change cannot leak into the captured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1     <= '0;
      a_s2     <= '0;
      b_s1     <= '0;
      b_s2     <= '0;
      result_q <= '0;
      any_q    <= 1'b0;
      acc_q    <= '0;
      mode_q   <= '0;
    end else begin
      a_s1     <= sw_a;
      a_s2     <= a_s1;
      b_s1     <= sw_b;
      b_s2     <= b_s1;
      result_q <= result_c;
      any_q    <= |result_c;
      if (load_p) acc_q <= result_q;
      if (mode_p) mode_q <= mode_q + 3'd1;
    end
  end

  assign led_result = result_q;
  assign led_mode   = mode_q;
  assign led_acc    = acc_q;
  assign led_any    = any_q;
endmodule

// File: tb/tb_logic_lab_unit.sv
// Self-checking bench for logic_lab_unit: directed scenarios plus randomized
// button/switch activity compared every cycle against a behavioural model.

module tb_logic_lab_unit;
  localparam int W   = 4;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw_a = '0;
  logic [W-1:0] sw_b = '0;
  logic         btn_mode = 1'b0;
  logic         btn_load = 1'b0;
  logic [W-1:0] led_result;
  logic [2:0]   led_mode;
  logic [W-1:0] led_acc;
  logic         led_any;

  int check_count = 0;
  int pass_count  = 0;
  bit chk_en      = 1'b0;

  logic_lab_unit #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_a       (sw_a),
    .sw_b       (sw_b),
    .btn_mode   (btn_mode),
    .btn_load   (btn_load),
    .led_result (led_result),
    .led_mode   (led_mode),
    .led_acc    (led_acc),
    .led_any    (led_any)
  );

  always #5 clk = ~clk;

  // Behavioural reference: inputs seen two cycles late, buttons adopt a new
  // level after DEB consecutive disagreeing samples, a press is a rising level.
  logic [W-1:0] a_hist [2];
  logic [W-1:0] b_hist [2];
  logic         btn_hist [2][2];
  logic         m_level [2];
  logic         m_level_old [2];
  int           m_run [2];
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_acc = '0;
  int           m_mode = 0;
  logic         m_any = 1'b0;

  function automatic logic [W-1:0] ref_op(int op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
    case (op)
      0:       return ~a;
      1:       return a | b;
      2:       return a ^ b;
      3:       return a & b;
      4:       return ~(a & b);
      5:       return ~(a | b);
      6:       return ~(a ^ b);
      default: return a | b | c;
    endcase
  endfunction

  always @(posedge clk) begin
    logic         pressed [2];
    logic [W-1:0] nres;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        a_hist[i] = '0; b_hist[i] = '0;
        btn_hist[i][0] = 1'b0; btn_hist[i][1] = 1'b0;
        m_level[i] = 1'b0; m_level_old[i] = 1'b0; m_run[i] = 0;
      end
      m_res = '0; m_acc = '0; m_mode = 0; m_any = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) pressed[i] = m_level[i] && !m_level_old[i];
      nres = ref_op(m_mode, a_hist[1], b_hist[1], m_acc);
      if (pressed[1]) m_acc = m_res;
      if (pressed[0]) m_mode = (m_mode + 1) % 8;
      m_res = nres;
      m_any = (nres != 0);
      for (int i = 0; i < 2; i++) begin
        m_level_old[i] = m_level[i];
        if (btn_hist[i][1] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_level[i] = ~m_level[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      a_hist[1] = a_hist[0]; a_hist[0] = sw_a;
      b_hist[1] = b_hist[0]; b_hist[0] = sw_b;
      btn_hist[0][1] = btn_hist[0][0]; btn_hist[0][0] = btn_mode;
      btn_hist[1][1] = btn_hist[1][0]; btn_hist[1][0] = btn_load;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model_result", 32'(led_result), 32'(m_res));
      checkOutput("model_mode", 32'(led_mode), 32'(m_mode));
      checkOutput("model_acc", 32'(led_acc), 32'(m_acc));
      checkOutput("model_any", 32'(led_any), 32'(m_any));
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    btn_mode = 1'b0;
    btn_load = 1'b0;
    waitCycles(2);
    checkOutput("rst_result", 32'(led_result), 32'd0);
    checkOutput("rst_mode", 32'(led_mode), 32'd0);
    checkOutput("rst_acc", 32'(led_acc), 32'd0);
    checkOutput("rst_any", 32'(led_any), 32'd0);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic m, input logic l, input int hold, input int gap);
    btn_mode = m;
    btn_load = l;
    waitCycles(hold);
    btn_mode = 1'b0;
    btn_load = 1'b0;
    waitCycles(gap);
  endtask

  task automatic setSwitches(input logic [W-1:0] a, input logic [W-1:0] b);
    sw_a = a;
    sw_b = b;
    waitCycles(4);
  endtask

  initial begin
    int mhold;
    int lhold;
    doReset();
    chk_en = 1'b1;

    // Idle after reset, then switch-to-LED latency in mode 0.
    waitCycles(50);
    checkOutput("idle_mode", 32'(led_mode), 32'd0);
    sw_a = 4'b1010;
    sw_b = 4'b0110;
    waitCycles(2);
    checkOutput("lat_2cyc", 32'(led_result), 32'b1111);
    waitCycles(1);
    checkOutput("lat_3cyc", 32'(led_result), 32'b0101);

    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("op1", 32'(led_result), 32'b1110);
    checkOutput("op1_any", 32'(led_any), 32'd1);
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("op2", 32'(led_result), 32'b1100);
    applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("op3", 32'(led_result), 32'b0010);
    checkOutput("op3_any", 32'(led_any), 32'd1);
    repeat (3) applyStimulus(1'b1, 1'b0, 8, 8);
    checkOutput("op6", 32'(led_result), 32'b0011);
    checkOutput("op6_any", 32'(led_any), 32'd1);

    // Glitches shorter than the debounce window, then one long hold.
    doReset();
    applyStimulus(1'b1, 1'b0, 3, 2);
    applyStimulus(1'b1, 1'b0, 3, 10);
    checkOutput("glitch_mode", 32'(led_mode), 32'd0);
    btn_mode = 1'b1;
    waitCycles(20);
    checkOutput("hold_mode", 32'(led_mode), 32'd1);
    btn_mode = 1'b0;
    waitCycles(10);
    checkOutput("release_mode", 32'(led_mode), 32'd1);

    doReset();
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 8, 8);
      checkOutput("wrap_mode", 32'(led_mode), 32'(k % 8));
    end

    // Accumulator capture and feedback in the 3-input OR mode.
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 8, 8);
    setSwitches(4'b0011, 4'b0001);
    checkOutput("acc_src", 32'(led_result), 32'b0001);
    applyStimulus(1'b0, 1'b1, 8, 8);
    checkOutput("acc_load", 32'(led_acc), 32'b0001);
    repeat (4) applyStimulus(1'b1, 1'b0, 8, 8);
    setSwitches(4'b0100, 4'b0000);
    checkOutput("or3", 32'(led_result), 32'b0101);
    setSwitches(4'b0000, 4'b0000);
    checkOutput("or3_acc_only", 32'(led_result), 32'b0001);
    checkOutput("or3_any", 32'(led_any), 32'd1);
    repeat (6) applyStimulus(1'b1, 1'b0, 8, 8);
    setSwitches(4'b1111, 4'b1111);
    checkOutput("nor_zero", 32'(led_result), 32'd0);
    checkOutput("nor_any", 32'(led_any), 32'd0);

    // Simultaneous mode and load presses.
    doReset();
    applyStimulus(1'b1, 1'b0, 8, 8);
    setSwitches(4'b1010, 4'b0110);
    checkOutput("sim_pre", 32'(led_result), 32'b1110);
    applyStimulus(1'b1, 1'b1, 8, 8);
    checkOutput("sim_acc", 32'(led_acc), 32'b1110);
    checkOutput("sim_mode", 32'(led_mode), 32'd2);

    // Reset in the middle of a load debounce.
    btn_load = 1'b1;
    waitCycles(4);
    rst = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      waitCycles(1);
      checkOutput("rstmid_acc0", 32'(led_acc), 32'd0);
    end
    waitCycles(2);
    checkOutput("rstmid_acc", 32'(led_acc), 32'b0101);
    btn_load = 1'b0;
    waitCycles(10);

    // Randomized activity with occasional resets.
    mhold = 0;
    lhold = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) sw_a = W'($urandom);
      if ($urandom_range(0, 5) == 0) sw_b = W'($urandom);
      if (mhold == 0) begin
        btn_mode = ~btn_mode;
        mhold = $urandom_range(1, 9);
      end else mhold--;
      if (lhold == 0) begin
        btn_load = ~btn_load;
        lhold = $urandom_range(1, 9);
      end else lhold--;
      rst = ($urandom_range(0, 399) == 0);
      waitCycles(1);
    end
    rst = 1'b0;
    waitCycles(2);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
